opb_register_poller: RTL

- OPB master (initiator) that periodically or on demand reads one 32-bit software register on the OPB bus and hands the value to user logic.
- It is the other end of the OPB slave register path: the slave answers the read, and this block issues it.
- It is used to pull status/counter registers (e.g. gbe TX overflow counter at 0x010C0500) back into fabric logic for monitoring.
- Single clock domain, the OPB clock.

---
 rtl/opb_register_poller_if.sv | 63 ++++++
 rtl/opb_register_poller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/opb_register_poller_if.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_poller_if
// Brief    : OPB master-side bus bundle used by the register poller.
// Revision : 1.0 - initial release
// ============================================================================

interface opb_register_poller_if;
    logic        M_request;
    logic        M_select;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        M_RNW;
    logic        M_busLock;
    logic        M_seqAddr;

    logic        OPB_MGrant;
    logic [0:31] OPB_DBus;
    logic        OPB_xferAck;
    logic        OPB_errAck;
    logic        OPB_retry;
    logic        OPB_toutSup;
    logic        OPB_timeout;

    modport master (
        output M_request,
        output M_select,
        output M_ABus,
        output M_BE,
        output M_DBus,
        output M_RNW,
        output M_busLock,
        output M_seqAddr,
        input  OPB_MGrant,
        input  OPB_DBus,
        input  OPB_xferAck,
        input  OPB_errAck,
        input  OPB_retry,
        input  OPB_toutSup,
        input  OPB_timeout
    );

    modport slave (
        input  M_request,
        input  M_select,
        input  M_ABus,
        input  M_BE,
        input  M_DBus,
        input  M_RNW,
        input  M_busLock,
        input  M_seqAddr,
        output OPB_MGrant,
        output OPB_DBus,
        output OPB_xferAck,
        output OPB_errAck,
        output OPB_retry,
        output OPB_toutSup,
        output OPB_timeout
    );
endinterface

`default_nettype wire

// File: rtl/opb_register_poller.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_poller
// Brief    : OPB master that reads one 32-bit register periodically or on
//            demand and presents the value to fabric logic.
// Revision : 1.0 - initial release
// ============================================================================

module opb_register_poller #(
    parameter logic [31:0] C_TARGET_ADDR = 32'h010C0500,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_POLL_PERIOD = 1024,
    parameter int          C_TIMEOUT     = 16,
    parameter int          C_MAX_RETRY   = 4
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst_n,
    opb_register_poller_if.master        bus,
    input  logic                         poll_en,
    input  logic                         poll_now,
    output logic [31:0]                  user_data_out,
    output logic                         user_data_valid,
    output logic                         user_err,
    output logic                         busy
);

    localparam int C_PCNT_W  = $clog2(C_POLL_PERIOD);
    localparam int C_WAIT_W  = $clog2(C_TIMEOUT + 1);
    localparam int C_RETRY_W = $clog2(C_MAX_RETRY + 1);

    localparam logic [C_PCNT_W-1:0]     C_PERIOD_LAST  = C_PCNT_W'(C_POLL_PERIOD - 1);
    localparam logic [C_WAIT_W-1:0]     C_TIMEOUT_LAST = C_WAIT_W'(C_TIMEOUT - 1);
    localparam logic [C_RETRY_W-1:0]    C_RETRY_LAST   = C_RETRY_W'(C_MAX_RETRY - 1);
    localparam logic [C_OPB_AWIDTH-1:0] C_ADDR         = C_OPB_AWIDTH'(C_TARGET_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [C_PCNT_W-1:0]     r_period_cnt;
    logic [C_WAIT_W-1:0]     r_wait_cnt;
    logic [C_RETRY_W-1:0]    r_retry_cnt;
    logic                    r_pending;
    logic [C_OPB_DWIDTH-1:0] r_data;
    logic                    r_valid;
    logic                    r_err;

    logic                    w_period_hit;
    logic                    w_tout_hit;
    logic                    w_trigger;
    logic                    w_done_ok;
    logic                    w_done_err;
    logic                    w_retry_again;
    logic                    w_select;

    assign w_period_hit = poll_en && (r_period_cnt == C_PERIOD_LAST);
    // The wait budget is spent on the cycle whose increment would reach C_TIMEOUT.
    assign w_tout_hit   = !bus.OPB_toutSup && (r_wait_cnt == C_TIMEOUT_LAST);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_trigger     = 1'b0;
        w_done_ok     = 1'b0;
        w_done_err    = 1'b0;
        w_retry_again = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_period_hit || poll_now || r_pending) begin
                    w_trigger    = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.OPB_MGrant) begin
                    w_state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                // errAck outranks xferAck, so a simultaneous pair is an error.
                if (bus.OPB_errAck || bus.OPB_timeout || w_tout_hit) begin
                    w_done_err   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (bus.OPB_retry) begin
                    if (r_retry_cnt == C_RETRY_LAST) begin
                        w_done_err   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_retry_again = 1'b1;
                        w_state_next  = ST_REQ;
                    end
                end else if (bus.OPB_xferAck) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_period_cnt <= '0;
            r_wait_cnt   <= '0;
            r_retry_cnt  <= '0;
            r_pending    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Period is measured trigger to trigger; it holds while a read is in flight.
            if (w_trigger) begin
                r_period_cnt <= '0;
            end else if (r_state == ST_IDLE) begin
                r_period_cnt <= poll_en ? (r_period_cnt + 1'b1) : '0;
            end

            if (w_trigger) begin
                r_pending <= 1'b0;
            end else if ((r_state != ST_IDLE) && (poll_now || w_period_hit)) begin
                r_pending <= 1'b1;
            end

            if (w_trigger) begin
                r_retry_cnt <= '0;
            end else if (w_retry_again) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end

            if (r_state != ST_XFER) begin
                r_wait_cnt <= '0;
            end else if (!bus.OPB_toutSup) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_done_ok) begin
                r_data <= bus.OPB_DBus;
            end

            r_valid <= w_done_ok;
            r_err   <= w_done_err;
        end
    end

    // Address phase outputs are gated by select so the OR-ed bus stays clean.
    assign w_select      = (r_state == ST_XFER);
    assign bus.M_request = (r_state == ST_REQ);
    assign bus.M_select  = w_select;
    assign bus.M_ABus    = w_select ? C_ADDR : '0;
    assign bus.M_BE      = w_select ? 4'b1111 : 4'b0000;
    assign bus.M_RNW     = w_select;
    assign bus.M_DBus    = '0;
    assign bus.M_busLock = 1'b0;
    assign bus.M_seqAddr = 1'b0;

    assign user_data_out   = r_data;
    assign user_data_valid = r_valid;
    assign user_err        = r_err;
    assign busy            = (r_state != ST_IDLE);

endmodule

`default_nettype wire
